// File: rtl/attn_pkg.sv
// attn_pkg: precision encodings and helpers shared by the attention selectors and the A·V multiplier
package attn_pkg;
  typedef enum logic [1:0] {
    PREC_INT4 = 2'b00,
    PREC_INT8 = 2'b01,
    PREC_FP16 = 2'b10
  } prec_t;
  localparam int CYCLES_INT4 = 1;
  localparam int CYCLES_INT8 = 2;
  localparam int CYCLES_FP16 = 4;
  // 0x8000 maps to 32768, which still fits the unsigned 16-bit magnitude
  function automatic logic [15:0] abs16(input logic [15:0] x);
    return x[15] ? 16'(~x + 16'd1) : x;
  endfunction
endpackage

// File: rtl/precision_classifier.sv
// precision_classifier: maps a column score onto INT4/INT8/FP16 with FP16 taking priority
module precision_classifier
  import attn_pkg::*;
#(
  parameter int SCORE_W = 19
) (
  input  logic [SCORE_W-1:0] score,
  input  logic [SCORE_W-1:0] thr_hi,
  input  logic [SCORE_W-1:0] thr_lo,
  output logic [1:0]         sel
);
  always_comb sel = score >= thr_hi ? PREC_FP16 : score >= thr_lo ? PREC_INT8 : PREC_INT4;
endmodule

// File: rtl/attention_precision_select.sv
// attention_precision_select: scans A column by column, scores sum|A| and publishes per-column precision
module attention_precision_select
  import attn_pkg::*;
#(
  parameter int A_ROWS     = 8,
  parameter int NUM_COLS   = 8,
  parameter int WIDTH_FP16 = 16,
  parameter int SCORE_W    = WIDTH_FP16 + $clog2(A_ROWS)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [A_ROWS*NUM_COLS*WIDTH_FP16-1:0] a_mem,
  input  logic [SCORE_W-1:0]                   thr_hi,
  input  logic [SCORE_W-1:0]                   thr_lo,
  output logic [2*NUM_COLS-1:0]                precision_sel,
  output logic [SCORE_W*NUM_COLS-1:0]          col_score,
  output logic                                 busy,
  output logic                                 done
);
  localparam int RW = A_ROWS > 1 ? $clog2(A_ROWS) : 1;
  localparam int CW = NUM_COLS > 1 ? $clog2(NUM_COLS) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(A_ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(NUM_COLS - 1);
  typedef enum logic [1:0] {IDLE, SCAN, CLASSIFY, DONE} state_t;
  state_t                      state;
  logic [RW-1:0]               row;
  logic [CW-1:0]               col;
  logic [SCORE_W-1:0]          acc, thr_hi_q, thr_lo_q;
  logic [2*NUM_COLS-1:0]       shadow_sel, next_sel;
  logic [SCORE_W*NUM_COLS-1:0] shadow_score, next_score;
  logic [WIDTH_FP16-1:0]       elems [A_ROWS][NUM_COLS];
  logic [1:0]                  cls_sel;
  genvar i, c;
  generate
    for (i = 0; i < A_ROWS; i++) begin : g_row
      for (c = 0; c < NUM_COLS; c++) begin : g_col
        assign elems[i][c] = a_mem[(i*NUM_COLS+c)*WIDTH_FP16 +: WIDTH_FP16];
      end
    end
  endgenerate
  precision_classifier #(.SCORE_W(SCORE_W)) u_cls (
    .score (acc),
    .thr_hi(thr_hi_q),
    .thr_lo(thr_lo_q),
    .sel   (cls_sel)
  );
  // the last column is merged in here so the commit edge sees a complete set
  always_comb begin
    next_sel = shadow_sel;
    next_score = shadow_score;
    next_sel[col*2 +: 2] = cls_sel;
    next_score[col*SCORE_W +: SCORE_W] = acc;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      row           <= '0;
      col           <= '0;
      acc           <= '0;
      thr_hi_q      <= '0;
      thr_lo_q      <= '0;
      shadow_sel    <= '0;
      shadow_score  <= '0;
      precision_sel <= {NUM_COLS{2'b10}};
      col_score     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          thr_hi_q <= thr_hi;
          thr_lo_q <= thr_lo;
          row      <= '0;
          col      <= '0;
          acc      <= '0;
          busy     <= 1'b1;
          state    <= SCAN;
        end
        SCAN: begin
          acc <= acc + SCORE_W'(abs16(elems[row][col]));
          if (row == ROW_LAST) state <= CLASSIFY;
          else row <= row + RW'(1);
        end
        CLASSIFY: begin
          shadow_sel   <= next_sel;
          shadow_score <= next_score;
          acc          <= '0;
          row          <= '0;
          if (col == COL_LAST) begin
            precision_sel <= next_sel;
            col_score     <= next_score;
            done          <= 1'b1;
            state         <= DONE;
          end else begin
            col   <= col + CW'(1);
            state <= SCAN;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_attention_precision_select.sv
// tb_attention_precision_select: directed and randomized checks against a per-column |A| sum model
module tb_attention_precision_select;
  localparam int R = 8, C = 8, W = 16, SW = 19, LAT = 1 + C*(R+1);
  logic clk = 0, rst_n = 0, start = 0;
  logic [R*C*W-1:0] a_mem = '0;
  logic [SW-1:0] thr_hi = '0, thr_lo = '0;
  logic [2*C-1:0] precision_sel;
  logic [SW*C-1:0] col_score;
  logic busy, done;
  logic [2*C-1:0] exp_sel;
  logic [SW*C-1:0] exp_score;
  int total = 0, bad = 0;
  attention_precision_select dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_mem(a_mem), .thr_hi(thr_hi), .thr_lo(thr_lo),
    .precision_sel(precision_sel), .col_score(col_score), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic set_elem(input int i, input int c, input logic [15:0] v);
    a_mem[(i*C+c)*W +: W] = v;
  endtask
  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < R; i++) for (int c = 0; c < C; c++) set_elem(i, c, v);
  endtask
  task automatic model(input logic [SW-1:0] hi, input logic [SW-1:0] lo,
                       output logic [2*C-1:0] s, output logic [SW*C-1:0] sc);
    s = '0;
    sc = '0;
    for (int c = 0; c < C; c++) begin
      int sum = 0;
      for (int i = 0; i < R; i++) begin
        int v = $signed(a_mem[(i*C+c)*W +: W]);
        sum += (v < 0) ? -v : v;
      end
      sc[c*SW +: SW] = SW'(sum);
      s[c*2 +: 2] = (sum >= int'(hi)) ? 2'b10 : (sum >= int'(lo)) ? 2'b01 : 2'b00;
    end
  endtask
  task automatic run(input string tag, input bit pulse20, input bit scramble);
    logic [2*C-1:0] ns;
    logic [SW*C-1:0] nsc;
    int done_at = -1, dones = 0;
    model(thr_hi, thr_lo, ns, nsc);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    if (scramble) begin
      thr_hi = SW'($urandom_range(0, 300000));
      thr_lo = SW'($urandom_range(0, 300000));
    end
    for (int cyc = 1; cyc <= LAT + 3; cyc++) begin
      start = pulse20 && cyc == 20;
      if (done) begin
        dones++;
        if (done_at < 0) done_at = cyc;
      end
      chk({tag, "_busy"}, 256'(busy), 256'(cyc <= LAT));
      if (cyc < LAT) begin
        chk({tag, "_hold_sel"}, 256'(precision_sel), 256'(exp_sel));
        chk({tag, "_hold_score"}, 256'(col_score), 256'(exp_score));
      end
      if (cyc == LAT) chk({tag, "_sel_at_done"}, 256'(precision_sel), 256'(ns));
      @(posedge clk); #1;
    end
    start = 0;
    chk({tag, "_done_cycle"}, 256'(done_at), 256'(LAT));
    chk({tag, "_done_count"}, 256'(dones), 256'(1));
    chk({tag, "_sel"}, 256'(precision_sel), 256'(ns));
    chk({tag, "_score"}, 256'(col_score), 256'(nsc));
    exp_sel = ns;
    exp_score = nsc;
  endtask
  initial begin
    exp_sel = {C{2'b10}};
    exp_score = '0;
    @(posedge clk); #1;
    chk("reset_sel", 256'(precision_sel), 256'(exp_sel));
    chk("reset_score", 256'(col_score), 256'(exp_score));
    chk("reset_busy", 256'(busy), 256'(0));
    chk("reset_done", 256'(done), 256'(0));
    rst_n = 1;
    @(posedge clk); #1;
    fill(16'h1000);
    thr_hi = 40000;
    thr_lo = 20000;
    run("uniform", 1'b0, 1'b0);
    chk("uniform_all_int8", 256'(precision_sel), 256'({C{2'b01}}));
    for (int i = 0; i < R; i++) begin
      set_elem(i, 0, 16'h4000);
      set_elem(i, 1, 16'h0100);
      set_elem(i, 2, 16'h0C00);
      set_elem(i, 3, 16'h8000);
      set_elem(i, 4, (i % 2) ? 16'h1000 : 16'hF000);
      for (int c = 5; c < C; c++) set_elem(i, c, 16'($urandom));
    end
    run("mixed", 1'b0, 1'b0);
    chk("mixed_cols0to4", 256'(precision_sel[9:0]), 256'({2'b01, 2'b10, 2'b01, 2'b00, 2'b10}));
    chk("mixed_col3_score", 256'(col_score[3*SW +: SW]), 256'(262144));
    fill(16'h1000);
    thr_hi = 32768;
    thr_lo = 32768;
    run("equal_thr", 1'b0, 1'b0);
    chk("equal_thr_fp16", 256'(precision_sel), 256'({C{2'b10}}));
    thr_hi = 40000;
    thr_lo = 50000;
    run("lo_above_hi", 1'b0, 1'b0);
    chk("lo_above_hi_int4", 256'(precision_sel), 256'(0));
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < R; i++) for (int c = 0; c < C; c++) set_elem(i, c, 16'($urandom));
      thr_hi = SW'($urandom_range(0, 300000));
      thr_lo = SW'($urandom_range(0, 300000));
      run("random", 1'b1, 1'b1);
    end
    start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int cyc = 1; cyc < 30; cyc++) begin
      @(posedge clk); #1;
    end
    rst_n = 0;
    #1;
    chk("midrst_sel", 256'(precision_sel), 256'({C{2'b10}}));
    chk("midrst_score", 256'(col_score), 256'(0));
    chk("midrst_busy", 256'(busy), 256'(0));
    begin
      int d = 0;
      for (int cyc = 0; cyc < 50; cyc++) begin
        if (cyc == 3) rst_n = 1;
        d += int'(done);
        @(posedge clk); #1;
      end
      chk("midrst_no_done", 256'(d), 256'(0));
    end
    exp_sel = {C{2'b10}};
    exp_score = '0;
    fill(16'hFC00);
    thr_hi = 40000;
    thr_lo = 20000;
    run("after_reset", 1'b0, 1'b0);
    begin
      int d0 = -1, d1 = -1;
      start = 1;
      @(posedge clk); #1;
      for (int cyc = 1; cyc <= 2*LAT + 5; cyc++) begin
        if (done && d0 < 0) d0 = cyc;
        else if (done && d1 < 0) d1 = cyc;
        @(posedge clk); #1;
      end
      start = 0;
      chk("held_first_done", 256'(d0), 256'(LAT));
      chk("held_second_done", 256'(d1), 256'(2*LAT + 1));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
